// File: rtl/btn_debounce.sv
// Four-button debouncer with synchronizers, per-bit stability counters and a prioritised press event.
// Optional macro BTN_REVERSE_BLOCK_EN rejects presses that directly reverse the current direction.
module btn_debounce #(
    parameter int F_OSC           = 25175000,
    parameter int DEBOUNCE_CYCLES = F_OSC / 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_stable,
    output logic       trigger,
    output logic [1:0] dir
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef BTN_REVERSE_BLOCK_EN
    localparam logic REV_BLOCK = 1'b1;
`else
    localparam logic REV_BLOCK = 1'b0;
`endif

    logic [3:0]         sync1_r;
    logic [3:0]         sync2_r;
    logic [3:0][CW-1:0] cnt_r;
    logic [3:0]         btn_stable_r;
    logic               trigger_r;
    logic [1:0]         dir_r;

    logic [3:0] diff_s;
    logic [3:0] done_s;
    logic [3:0] rise_s;
    logic [3:0] blocked_s;
    logic       win_valid_s;
    logic [1:0] win_dir_s;

    // Per-bit mismatch, acceptance, rise and reversal-rejection flags.
    always_comb begin
        diff_s    = 4'b0000;
        done_s    = 4'b0000;
        rise_s    = 4'b0000;
        blocked_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            diff_s[i]    = sync2_r[i] ^ btn_stable_r[i];
            done_s[i]    = diff_s[i] && (cnt_r[i] == CNT_MAX);
            rise_s[i]    = done_s[i] && !btn_stable_r[i];
            blocked_s[i] = REV_BLOCK && (2'(i) == (dir_r ^ 2'b01));
        end
    end

    // Priority select: scanning downwards lets the lowest index win.
    always_comb begin
        win_valid_s = 1'b0;
        win_dir_s   = dir_r;
        for (int i = 3; i >= 0; i--) begin
            if (rise_s[i] && !blocked_s[i]) begin
                win_valid_s = 1'b1;
                win_dir_s   = 2'(i);
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Synchronizers, debounce counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r      <= 4'b0000;
            sync2_r      <= 4'b0000;
            cnt_r        <= '0;
            btn_stable_r <= 4'b0000;
            trigger_r    <= 1'b0;
            dir_r        <= 2'b11;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (!diff_s[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (done_s[i]) begin
                    cnt_r[i]        <= CNT_ZERO;
                    btn_stable_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
            trigger_r <= win_valid_s;
            if (win_valid_s) begin
                dir_r <= win_dir_s;
            end else begin
                dir_r <= dir_r;
            end
        end
    end

    assign btn_stable = btn_stable_r;
    assign trigger    = trigger_r;
    assign dir        = dir_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed table, hand-written corner sequences and
// randomized stimulus against a sliding-window reference model.
module tb_btn_debounce;

    localparam int D = 4;
`ifdef BTN_REVERSE_BLOCK_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_stable;
    logic       trigger;
    logic [1:0] dir;

    always #5 clk = ~clk;

    btn_debounce #(.F_OSC(400), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_stable (btn_stable),
        .trigger    (trigger),
        .dir        (dir)
    );

    int n_vec = 0;
    int n_err = 0;
    int trig_cnt = 0;

    // Reference model: a level is accepted once the last D synchronized samples all disagree with it.
    logic [3:0] m_s1, m_s2, m_stable;
    logic       m_trig;
    logic [1:0] m_dir;
    logic [3:0] m_hist[$];

    function automatic void model_reset();
        m_s1 = 4'b0000; m_s2 = 4'b0000; m_stable = 4'b0000;
        m_trig = 1'b0; m_dir = 2'b11;
        m_hist.delete();
        for (int k = 0; k < D; k++) m_hist.push_back(4'b0000);
    endfunction

    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] nxt;
        logic [3:0] rise;
        logic       found;
        logic       all_diff;
        logic [1:0] ndir;
        nxt = m_stable;
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
        end
        rise  = nxt & ~m_stable;
        found = 1'b0;
        ndir  = m_dir;
        for (int b = 0; b < 4; b++) begin
            if (!found && rise[b] && !(REV && (2'(b) == (m_dir ^ 2'b01)))) begin
                found = 1'b1;
                ndir  = 2'(b);
            end
        end
        m_trig   = found;
        m_dir    = ndir;
        m_stable = nxt;
        m_s2     = m_s1;
        m_s1     = raw;
        m_hist.push_back(m_s2);
        void'(m_hist.pop_front());
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got stable=%b trig=%b dir=%b, want stable=%b trig=%b dir=%b",
                     name, $time, act[6:3], act[2], act[1:0], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] raw);
        btn_raw = raw;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(raw);
        #1;
        trig_cnt += int'(trigger);
    endtask

    task automatic tick(input logic [3:0] raw, input string name);
        step(raw);
        check(name, {btn_stable, trigger, dir}, {m_stable, m_trig, m_dir});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("reset_state", {btn_stable, trigger, dir}, {4'b0000, 1'b0, 2'b11});
        step(btn_raw);
        rst = 1'b0;
        trig_cnt = 0;
    endtask

    typedef struct {
        logic [3:0] raw;
        logic [3:0] stb;
        logic       trg;
        logic [1:0] dr;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [3:0] raw, input logic [3:0] stb,
                                input logic trg, input logic [1:0] dr, input int n);
        vec_t v;
        v.raw = raw; v.stb = stb; v.trg = trg; v.dr = dr;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    initial begin
        rst     = 1'b1;
        btn_raw = 4'b0000;
        model_reset();
        do_reset();

        // Press up, hold, release, idle, press again, release.
        add(4'b0001, 4'b0000, 1'b0, 2'b11, 5);
        add(4'b0001, 4'b0001, 1'b1, 2'b00, 1);
        add(4'b0001, 4'b0001, 1'b0, 2'b00, 3);
        add(4'b0000, 4'b0001, 1'b0, 2'b00, 5);
        add(4'b0000, 4'b0000, 1'b0, 2'b00, 4);
        add(4'b0001, 4'b0000, 1'b0, 2'b00, 5);
        add(4'b0001, 4'b0001, 1'b1, 2'b00, 1);
        add(4'b0001, 4'b0001, 1'b0, 2'b00, 2);
        add(4'b0000, 4'b0001, 1'b0, 2'b00, 5);
        add(4'b0000, 4'b0000, 1'b0, 2'b00, 2);
        foreach (tbl[i]) begin
            step(tbl[i].raw);
            check("table", {btn_stable, trigger, dir}, {tbl[i].stb, tbl[i].trg, tbl[i].dr});
        end
        check_int("table_trigger_count", trig_cnt, 2);

        // Glitches on left never reach the stable level.
        do_reset();
        for (int k = 0; k < 3; k++) tick(4'b0100, "glitch");
        tick(4'b0000, "glitch");
        for (int k = 0; k < 2; k++) tick(4'b0100, "glitch");
        for (int k = 0; k < 8; k++) tick(4'b0000, "glitch");
        check_int("glitch_trigger_count", trig_cnt, 0);
        check("glitch_final", {btn_stable, trigger, dir}, {4'b0000, 1'b0, 2'b11});

        // Up and left together: a single trigger, up wins.
        do_reset();
        for (int k = 0; k < 8; k++) tick(4'b0101, "simul");
        check_int("simul_trigger_count", trig_cnt, 1);
        check("simul_final", {btn_stable, trigger, dir}, {4'b0101, 1'b0, 2'b00});

        // Left while facing right: a direct reversal.
        do_reset();
        for (int k = 0; k < 8; k++) tick(4'b0100, "reverse");
        check_int("reverse_trigger_count", trig_cnt, REV ? 0 : 1);
        check("reverse_final", {btn_stable, trigger, dir},
              {4'b0100, 1'b0, (REV ? 2'b11 : 2'b10)});

        // Reset in the middle of a debounce with down held throughout.
        do_reset();
        for (int k = 0; k < 3; k++) tick(4'b0010, "mid_reset_pre");
        check_int("mid_reset_pre_count", trig_cnt, 0);
        do_reset();
        for (int k = 0; k < 5; k++) tick(4'b0010, "mid_reset_wait");
        check_int("mid_reset_no_early", trig_cnt, 0);
        tick(4'b0010, "mid_reset_fire");
        check("mid_reset_fire_exact", {btn_stable, trigger, dir}, {4'b0010, 1'b1, 2'b01});
        for (int k = 0; k < 4; k++) tick(4'b0010, "mid_reset_hold");
        check_int("mid_reset_trigger_count", trig_cnt, 1);

        // Randomized buttons with occasional resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] r;
            r = btn_raw;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 699) == 0) do_reset();
            tick(r, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter: F_OSC, 25175000, pixel/system clock frequency in Hz.
REQ-002 Parameter: DEBOUNCE_CYCLES, F_OSC/100 (10 ms), number of consecutive stable cycles required to accept a level change; SHALL be >= 2.
REQ-003 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: btn_raw  input  4  raw active-high buttons, asynchronous to clk; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-006 Port: btn_stable  output  4  debounced button levels, registered.
REQ-007 Port: trigger  output  1  one-cycle press event, registered; intended to drive the trigger input of the downstream pulse generator.
REQ-008 Port: dir  output  2  last accepted direction, registered: 00 up, 01 down, 10 left, 11 right.

Function
REQ-009 Each btn_raw bit SHALL pass through a two-flop synchronizer; only the second-flop value (sync) is used downstream.
REQ-010 Each bit SHALL have an independent counter, width $clog2(DEBOUNCE_CYCLES).
REQ-011 Counter SHALL clear on any cycle where sync equals btn_stable for that bit.
REQ-012 While sync differs from btn_stable, counter SHALL increment; on the edge where it equals DEBOUNCE_CYCLES-1 and sync still differs, btn_stable SHALL take sync and the counter SHALL clear (no wrap past DEBOUNCE_CYCLES-1).
REQ-013 A rise event for a bit SHALL occur on the edge where its btn_stable changes 0->1; falling changes SHALL generate no event.
REQ-014 On a cycle with at least one accepted rise event, trigger SHALL be 1 for exactly that one following cycle and dir SHALL update on the same edge; otherwise trigger SHALL be 0 and dir SHALL hold.
REQ-015 Simultaneous rise events SHALL resolve by fixed priority bit0 > bit1 > bit2 > bit3; only the winner updates dir; one trigger pulse.
REQ-016 Latency: a clean raw 0->1 transition sampled at edge N SHALL produce btn_stable=1 and trigger=1 after edge N+1+DEBOUNCE_CYCLES.
REQ-017 Held buttons SHALL NOT retrigger; a new trigger requires the bit to go stable-low and then stable-high again.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES sync cycles SHALL leave btn_stable, trigger and dir unchanged.

Reset
REQ-019 While rst=1: synchronizer flops 0, counters 0, btn_stable 4'b0000, trigger 0, dir 2'b11 (right).
REQ-020 Reset asserted mid-debounce SHALL discard partial counts; after release, debouncing restarts from zero with no spurious trigger.
REQ-021 A button already held when rst deasserts SHALL produce exactly one trigger after full synchronizer + debounce latency.

Configuration
REQ-022 Macro BTN_REVERSE_BLOCK_EN: when defined, a rise event whose direction equals dir XOR 2'b01 (direct reversal) SHALL be rejected: no trigger, dir unchanged, btn_stable still updates; in a simultaneous case the highest-priority non-rejected event wins.
REQ-023 When BTN_REVERSE_BLOCK_EN is undefined, every winning rise event SHALL be accepted per REQ-014/REQ-015.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Reset, then btn_raw=4'b0001 held -> btn_stable[0]=1, trigger=1 for one cycle 6 edges after first sample, dir=00; no further triggers while held.
REQ-025 btn_raw[2] pulses high 3 cycles, low 1, high 2, then low -> trigger never asserted, dir stays 11, btn_stable stays 0.
REQ-026 From reset, btn_raw=4'b0101 raised same cycle -> single trigger, dir=00.
REQ-027 dir=11, press left (4'b0100) -> with BTN_REVERSE_BLOCK_EN: no trigger, dir=11, btn_stable[2]=1; without: one trigger, dir=10.
REQ-028 btn_raw[1] high 3 cycles, rst pulsed 1 cycle, btn_raw[1] kept high -> no trigger before reset; exactly one trigger 6 edges after rst deasserts, dir=01.
REQ-029 Press up and release, wait 8 cycles, press up again -> two triggers total, each one cycle wide; release produces none.
